cache_fill_controller: RTL and testbench
========================================

Name: cache_fill_controller

Overview:
- Sequences line fills into the set-associative cache on a miss.
- Accepts a miss request, fetches the line from the memory interface, picks the destination way (first invalid way, else a round-robin victim), and writes the tag/data arrays.
- Owns the per-set valid bits and victim pointers.
- Provides a whole-cache flush.
- Sits between the hit/miss lookup logic and the tag/data arrays.

Parameters:
NWAYS, 5, ways per set (need not be a power of two)
NSETS, 16, number of sets (power of two)
TAG_W, 20, tag width
DATA_W, 32, line data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fill_valid  in  1  miss request valid
fill_ready  out  1  controller can accept a miss
fill_set  in  $clog2(NSETS)  set index of miss
fill_tag  in  TAG_W  tag of miss
flush_req  in  1  level request to invalidate whole cache
flush_done  out  1  one-cycle pulse when flush completes
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  TAG_W+$clog2(NSETS)  {tag,set} line address
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_W  line data
arr_we  out  1  tag/data array write strobe
arr_set  out  $clog2(NSETS)  array write set
arr_way  out  $clog2(NWAYS)  array write way
arr_tag  out  TAG_W  tag to write
arr_data  out  DATA_W  data to write
fill_done  out  1  pulse, coincident with arr_we
fill_evict  out  1  valid with fill_done: 1 = a valid line was replaced
lookup_set  in  $clog2(NSETS)  set queried by hit logic
lookup_valid  out  NWAYS  combinational valid bits of lookup_set

Behaviour:
- One clock, synchronous active-low reset.
- Reset values:
  - State IDLE; all valid bits 0; all victim pointers 0.
  - All outputs 0, including fill_ready during reset.
  - An in-flight fill is discarded on reset; mem_req_valid drops the next edge.
- States: IDLE, MEM_REQ, MEM_WAIT, WRITE, FLUSH.
- IDLE:
  - fill_ready = !flush_req.
  - flush_req=1 goes to FLUSH, flush counter = 0. Flush has priority over a simultaneous fill_valid, which is not accepted.
  - fill_valid && fill_ready latches set/tag and goes to MEM_REQ.
- MEM_REQ:
  - mem_req_valid=1 with a stable mem_req_addr={tag,set}.
  - On mem_req_ready go to MEM_WAIT.
- MEM_WAIT:
  - On mem_rsp_valid, latch data and go to WRITE.
  - mem_rsp_valid in any other state is ignored.
- Way selection, evaluated on entry to WRITE from the current valid bits of the latched set:
  - Lowest-index invalid way, fill_evict=0.
  - If all ways are valid: way = victim_ptr[set], fill_evict=1, victim_ptr[set] increments, wrapping NWAYS-1 -> 0.
  - The pointer is unchanged when an invalid way is used.
- WRITE (exactly one cycle):
  - arr_we=1, fill_done=1.
  - arr_set/arr_way/arr_tag/arr_data driven.
  - Valid bit of the chosen way set at the clock edge.
  - Returns to IDLE.
- Minimum latency: acceptance at cycle T, arr_we at T+3 (ready/rsp held high). fill_ready is low from T+1 until back in IDLE.
- FLUSH:
  - Clears valid bits and victim pointer of one set per cycle, set 0..NSETS-1.
  - flush_done pulses in the cycle clearing set NSETS-1; then IDLE.
  - Takes NSETS cycles; fill_ready=0 throughout.
  - flush_req is sampled only in IDLE.
- lookup_valid reflects register state: a write in cycle T is visible from T+1.
- No duplicate-tag check; the requester guarantees a missed line is not already resident.
- arr_* outputs hold their last value when arr_we=0.

Optional Feature:
- Macro: CACHE_FILL_STATS_EN
- Defined:
  - Adds output ports fill_count[31:0] and evict_count[31:0].
  - fill_count increments on each fill_done; evict_count increments on fill_done && fill_evict.
  - Both counters saturate at all-ones.
  - Cleared by reset only; flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then a fill for set 3 / tag 0x00ABC with ready and rsp immediate -> arr_we at T+3, arr_way=0, fill_evict=0, mem_req_addr={0x00ABC,3}, lookup_valid(set 3)=5'b00001 next cycle.
- Five fills to set 7 -> ways 0,1,2,3,4. Then three more -> ways 0,1,2 with fill_evict=1, victim_ptr(7)=3. Two more -> ways 3,4, then wrap to 0.
- mem_req_ready held low 4 cycles and mem_rsp_valid delayed 6 cycles -> mem_req_valid/addr stable, no arr_we, fill_ready=0 throughout. A spurious mem_rsp_valid in IDLE has no effect.
- flush_req and fill_valid asserted together in IDLE -> fill not accepted, FLUSH runs 16 cycles, flush_done pulses once, all lookup_valid=0, victim pointers 0; the fill is then accepted next IDLE cycle.
- rst_n low while in MEM_WAIT -> next cycle IDLE, all outputs 0, valid bits cleared; a later rsp is ignored.
- With CACHE_FILL_STATS_EN: 8 fills to one set -> fill_count=8, evict_count=3; a flush leaves both unchanged.

Source files
------------

// File: rtl/cache_fill_controller.sv
// Miss-driven line fill sequencer: fetches a line, picks a way (first invalid, else round-robin victim), writes arrays; whole-cache flush.
// Latency: accept at T, arr_we at T+3 with mem ready/rsp immediate; flush takes NSETS cycles.
// Backpressure: fill_ready low outside IDLE and while flush_req is high; stalls on mem_req_ready / mem_rsp_valid.
// Optional: define CACHE_FILL_STATS_EN to add saturating fill_count / evict_count outputs.
module cache_fill_controller #(
  parameter int NWAYS  = 5,
  parameter int NSETS  = 16,
  parameter int TAG_W  = 20,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fill_valid,
  output logic                             fill_ready,
  input  logic [$clog2(NSETS)-1:0]         fill_set,
  input  logic [TAG_W-1:0]                 fill_tag,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [TAG_W+$clog2(NSETS)-1:0]   mem_req_addr,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_W-1:0]                mem_rsp_data,
  output logic                             arr_we,
  output logic [$clog2(NSETS)-1:0]         arr_set,
  output logic [$clog2(NWAYS)-1:0]         arr_way,
  output logic [TAG_W-1:0]                 arr_tag,
  output logic [DATA_W-1:0]                arr_data,
  output logic                             fill_done,
  output logic                             fill_evict,
`ifdef CACHE_FILL_STATS_EN
  output logic [31:0]                      fill_count,
  output logic [31:0]                      evict_count,
`endif
  input  logic [$clog2(NSETS)-1:0]         lookup_set,
  output logic [NWAYS-1:0]                 lookup_valid
);

  localparam int SW = $clog2(NSETS);
  localparam int WW = $clog2(NWAYS);

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, WRITE, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [NWAYS-1:0]  valid_q [NSETS];
  logic [WW-1:0]     vptr_q  [NSETS];
  logic [SW-1:0]     req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [SW-1:0]     flush_cnt;
  logic [WW-1:0]     sel_way;
  logic              sel_evict;
  logic              flush_last;

  assign flush_last = (flush_cnt == SW'(NSETS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake/strobe outputs; everything is forced low while reset is held.
  always_comb begin
    state_nxt     = state;
    fill_ready    = 1'b0;
    mem_req_valid = 1'b0;
    arr_we        = 1'b0;
    fill_done     = 1'b0;
    flush_done    = 1'b0;
    case (state)
      IDLE: begin
        fill_ready = !flush_req;
        if (flush_req)       state_nxt = FLUSH;
        else if (fill_valid) state_nxt = MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) state_nxt = WRITE;
      end
      WRITE: begin
        arr_we    = 1'b1;
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      FLUSH: begin
        flush_done = flush_last;
        if (flush_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      fill_ready    = 1'b0;
      mem_req_valid = 1'b0;
      arr_we        = 1'b0;
      fill_done     = 1'b0;
      flush_done    = 1'b0;
    end
  end

  // Way choice for the latched set: lowest invalid way wins, otherwise the set's victim pointer.
  always_comb begin
    sel_way   = vptr_q[req_set];
    sel_evict = 1'b1;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!valid_q[req_set][i]) begin
        sel_way   = WW'(i);
        sel_evict = 1'b0;
      end
    end
  end

  // Request capture, array write port registers, valid bits, victim pointers and flush sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_set    <= '0;
      req_tag    <= '0;
      flush_cnt  <= '0;
      arr_set    <= '0;
      arr_way    <= '0;
      arr_tag    <= '0;
      arr_data   <= '0;
      fill_evict <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            flush_cnt <= '0;
          end else if (fill_valid) begin
            req_set <= fill_set;
            req_tag <= fill_tag;
          end
        end
        MEM_WAIT: begin
          // Way is resolved here so the arr_* registers are stable throughout WRITE.
          if (mem_rsp_valid) begin
            arr_set    <= req_set;
            arr_way    <= sel_way;
            arr_tag    <= req_tag;
            arr_data   <= mem_rsp_data;
            fill_evict <= sel_evict;
          end
        end
        WRITE: begin
          valid_q[arr_set][arr_way] <= 1'b1;
          if (fill_evict) begin
            vptr_q[arr_set] <= (vptr_q[arr_set] == WW'(NWAYS - 1)) ? '0 : vptr_q[arr_set] + 1'b1;
          end
        end
        FLUSH: begin
          valid_q[flush_cnt] <= '0;
          vptr_q[flush_cnt]  <= '0;
          flush_cnt          <= flush_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_addr = {req_tag, req_set};
  assign lookup_valid = rst_n ? valid_q[lookup_set] : '0;

`ifdef CACHE_FILL_STATS_EN
  // Saturating fill / eviction counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_count  <= '0;
      evict_count <= '0;
    end else if (fill_done) begin
      if (fill_count != '1) fill_count <= fill_count + 1'b1;
      if (fill_evict && evict_count != '1) evict_count <= evict_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller: fills, victim rotation, stalls, flush priority, mid-fill reset.
// Inputs change and outputs are sampled just after the rising edge.
// Expected values are hand-derived constants.
module tb_cache_fill_controller;
  logic        clk;
  logic        rst_n;
  logic        fill_valid;
  logic        fill_ready;
  logic [3:0]  fill_set;
  logic [19:0] fill_tag;
  logic        flush_req;
  logic        flush_done;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [23:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        arr_we;
  logic [3:0]  arr_set;
  logic [2:0]  arr_way;
  logic [19:0] arr_tag;
  logic [31:0] arr_data;
  logic        fill_done;
  logic        fill_evict;
  logic [3:0]  lookup_set;
  logic [4:0]  lookup_valid;
`ifdef CACHE_FILL_STATS_EN
  logic [31:0] fill_count;
  logic [31:0] evict_count;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt;

  cache_fill_controller #(.NWAYS(5), .NSETS(16), .TAG_W(20), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set), .fill_tag(fill_tag),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .arr_we(arr_we), .arr_set(arr_set), .arr_way(arr_way), .arr_tag(arr_tag), .arr_data(arr_data),
    .fill_done(fill_done), .fill_evict(fill_evict),
`ifdef CACHE_FILL_STATS_EN
    .fill_count(fill_count), .evict_count(evict_count),
`endif
    .lookup_set(lookup_set), .lookup_valid(lookup_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fill with memory ready/response immediately available; checks T+3 write timing.
  task automatic do_fill(input logic [3:0] s, input logic [19:0] t, input logic [2:0] exp_way,
                         input logic exp_evict, input logic [4:0] exp_lv);
    fill_valid = 1'b1; fill_set = s; fill_tag = t; lookup_set = s;
    #1;
    chk("fill_ready_idle", fill_ready, 1'b1);
    step();
    fill_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = {12'hD00, t};
    #1;
    chk("mem_req_valid", mem_req_valid, 1'b1);
    chk("mem_req_addr", mem_req_addr, {t, s});
    chk("fill_ready_busy", fill_ready, 1'b0);
    step();
    chk("no_we_in_wait", arr_we, 1'b0);
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("arr_we", arr_we, 1'b1);
    chk("fill_done", fill_done, 1'b1);
    chk("arr_way", arr_way, exp_way);
    chk("fill_evict", fill_evict, exp_evict);
    chk("arr_set", arr_set, s);
    chk("arr_tag", arr_tag, t);
    chk("arr_data", arr_data, {12'hD00, t});
    step();
    chk("we_dropped", arr_we, 1'b0);
    chk("lookup_valid_after_fill", lookup_valid, exp_lv);
  endtask

  initial begin
    rst_n = 1'b0; fill_valid = 1'b0; fill_set = '0; fill_tag = '0; flush_req = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; lookup_set = 4'd3;

    // Reset state.
    step(); step();
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_arr_we", arr_we, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_lookup", lookup_valid, 5'b00000);
    chk("rst_addr", mem_req_addr, 24'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", fill_ready, 1'b1);

    // First fill: set 3, tag 0x00ABC.
    do_fill(4'd3, 20'h00ABC, 3'd0, 1'b0, 5'b00001);

    // Set 7: five fills into free ways, then round-robin eviction with wrap.
    do_fill(4'd7, 20'h70000, 3'd0, 1'b0, 5'b00001);
    do_fill(4'd7, 20'h70001, 3'd1, 1'b0, 5'b00011);
    do_fill(4'd7, 20'h70002, 3'd2, 1'b0, 5'b00111);
    do_fill(4'd7, 20'h70003, 3'd3, 1'b0, 5'b01111);
    do_fill(4'd7, 20'h70004, 3'd4, 1'b0, 5'b11111);
    do_fill(4'd7, 20'h70005, 3'd0, 1'b1, 5'b11111);
    do_fill(4'd7, 20'h70006, 3'd1, 1'b1, 5'b11111);
    do_fill(4'd7, 20'h70007, 3'd2, 1'b1, 5'b11111);
    do_fill(4'd7, 20'h70008, 3'd3, 1'b1, 5'b11111);
    do_fill(4'd7, 20'h70009, 3'd4, 1'b1, 5'b11111);
    do_fill(4'd7, 20'h7000A, 3'd0, 1'b1, 5'b11111);

    // Memory stalls: request held 4 cycles, response delayed 6 cycles.
    fill_valid = 1'b1; fill_set = 4'd2; fill_tag = 20'h12345; lookup_set = 4'd2;
    step();
    fill_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", mem_req_valid, 1'b1);
      chk("stall_req_addr", mem_req_addr, 24'h123452);
      chk("stall_req_ready", fill_ready, 1'b0);
      chk("stall_req_we", arr_we, 1'b0);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("stall_req_last", mem_req_valid, 1'b1);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stall_wait_req", mem_req_valid, 1'b0);
      chk("stall_wait_we", arr_we, 1'b0);
      chk("stall_wait_ready", fill_ready, 1'b0);
      step();
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
    step();
    mem_rsp_valid = 1'b0;
    chk("stall_we", arr_we, 1'b1);
    chk("stall_way", arr_way, 3'd0);
    chk("stall_evict", fill_evict, 1'b0);
    chk("stall_tag", arr_tag, 20'h12345);
    chk("stall_data", arr_data, 32'hCAFEF00D);
    step();
    // Spurious response while idle.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("spur_we", arr_we, 1'b0);
      chk("spur_req", mem_req_valid, 1'b0);
      chk("spur_ready", fill_ready, 1'b1);
    end
    mem_rsp_valid = 1'b0;
    chk("spur_data_hold", arr_data, 32'hCAFEF00D);
    chk("spur_lookup", lookup_valid, 5'b00001);

    // Flush and fill requested together: flush wins.
    flush_req = 1'b1; fill_valid = 1'b1; fill_set = 4'd9; fill_tag = 20'h55555; lookup_set = 4'd3;
    #1;
    chk("flush_blocks_ready", fill_ready, 1'b0);
    step();
    flush_req = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      chk("flush_ready_low", fill_ready, 1'b0);
      chk("flush_no_req", mem_req_valid, 1'b0);
      chk("flush_done_timing", flush_done, (i == 15));
      done_cnt += int'(flush_done);
      step();
    end
    chk("flush_done_once", done_cnt, 1);
    chk("flush_set3_clear", lookup_valid, 5'b00000);
    lookup_set = 4'd7;
    #1;
    chk("flush_set7_clear", lookup_valid, 5'b00000);
    lookup_set = 4'd2;
    #1;
    chk("flush_set2_clear", lookup_valid, 5'b00000);
    do_fill(4'd9, 20'h55555, 3'd0, 1'b0, 5'b00001);
    // Victim pointer of set 7 must be back at 0.
    do_fill(4'd7, 20'h71000, 3'd0, 1'b0, 5'b00001);
    do_fill(4'd7, 20'h71001, 3'd1, 1'b0, 5'b00011);
    do_fill(4'd7, 20'h71002, 3'd2, 1'b0, 5'b00111);
    do_fill(4'd7, 20'h71003, 3'd3, 1'b0, 5'b01111);
    do_fill(4'd7, 20'h71004, 3'd4, 1'b0, 5'b11111);
    do_fill(4'd7, 20'h71005, 3'd0, 1'b1, 5'b11111);

    // Reset while waiting for the memory response.
    fill_valid = 1'b1; fill_set = 4'd4; fill_tag = 20'h0F0F0;
    step();
    fill_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst_n = 1'b0; lookup_set = 4'd7;
    step();
    chk("mid_rst_ready", fill_ready, 1'b0);
    chk("mid_rst_req", mem_req_valid, 1'b0);
    chk("mid_rst_we", arr_we, 1'b0);
    chk("mid_rst_way", arr_way, 3'd0);
    chk("mid_rst_lookup", lookup_valid, 5'b00000);
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADF00D;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("late_rsp_we", arr_we, 1'b0);
      chk("late_rsp_ready", fill_ready, 1'b1);
    end
    mem_rsp_valid = 1'b0;
    chk("late_rsp_lookup", lookup_valid, 5'b00000);

    // Eight fills to set 1, then a flush.
    for (int i = 0; i < 8; i++) begin
      do_fill(4'd1, 20'h10000 + 20'(i), 3'(i % 5), (i >= 5), (i < 5) ? 5'((1 << (i + 1)) - 1) : 5'b11111);
    end
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count", fill_count, 32'd8);
    chk("evict_count", evict_count, 32'd3);
`endif
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 16; i++) step();
    lookup_set = 4'd1;
    #1;
    chk("flush2_ready", fill_ready, 1'b1);
    chk("flush2_set1_clear", lookup_valid, 5'b00000);
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count_kept", fill_count, 32'd8);
    chk("evict_count_kept", evict_count, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
